// File: rtl/reg_display_scan_pkg.sv
// Shared constants and helpers for the register display front panel.
//   - Legal selector range. The t0..t9 registers map to selector values 8..25.
//   - The s-register window 16..23, which lights the decimal point on the leftmost digit.
//   - A hex-to-7-segment table. Codes are active-low and ordered {g,f,e,d,c,b,a}.
package reg_display_scan_pkg;

    localparam logic [4:0] REG_SEL_MIN = 5'd8;
    localparam logic [4:0] REG_SEL_MAX = 5'd25;
    localparam logic [4:0] S_REG_LO    = 5'd16;
    localparam logic [4:0] S_REG_HI    = 5'd23;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/reg_display_scan_btn_debounce.sv
// Push-button conditioner.
// A two-flop synchronizer feeds a stability counter. When the counter
// accepts a new level, a rising edge of that level produces a one-cycle
// press pulse. Releases are filtered in the same way but never produce a pulse.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   btn_i       raw asynchronous button, active-high
//   pulse_o     one-cycle pulse per accepted press
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             sync_lvl;

    assign sync_lvl = sync_q[1];

    // Any sample that agrees with the accepted level restarts the count.
    // As a result, a glitch shorter than DB_CYCLES is never accepted.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        if (sync_lvl == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_lvl;
            cnt_d    = '0;
            pulse_d  = sync_lvl;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/reg_display_scan.sv
// Front-panel display stage for the register-file tap.
// It holds the 5-bit register selector, which two debounced buttons step
// through the legal range 8..25 with wrap-around. It shows the selected 32-bit
// value as eight hex digits on a multiplexed common-anode 7-segment display.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   btn_next, btn_prev  raw buttons; advance / step back the selection
//   value               register value selected by the external mux
//   sel                 selector driven to the mux
//   an                  digit anodes, active-low; an[0] is the rightmost digit
//   seg                 segments {g,f,e,d,c,b,a}, active-low
//   dp                  decimal point, active-low
module reg_display_scan
    import reg_display_scan_pkg::*;
#(
    parameter int DB_CYCLES = 500000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic [31:0] value,
    output logic [4:0]  sel,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic next_pulse, prev_pulse;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_next),
        .pulse_o (next_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_prev),
        .pulse_o (prev_pulse)
    );

    // ---------------- selector ----------------
    logic [4:0] sel_q, sel_d;
    logic       sel_out_of_range;

    assign sel_out_of_range = (sel_q < REG_SEL_MIN) || (sel_q > REG_SEL_MAX);

    // If both pulses arrive together they cancel. An illegal selector value
    // recovers to the bottom of the range on the next press.
    always_comb begin
        sel_d = sel_q;
        if (next_pulse && !prev_pulse) begin
            if (sel_out_of_range || sel_q == REG_SEL_MAX) sel_d = REG_SEL_MIN;
            else                                          sel_d = sel_q + 5'd1;
        end else if (prev_pulse && !next_pulse) begin
            if (sel_out_of_range)         sel_d = REG_SEL_MIN;
            else if (sel_q == REG_SEL_MIN) sel_d = REG_SEL_MAX;
            else                           sel_d = sel_q - 5'd1;
        end
    end

    // ---------------- scan and frame latch ----------------
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [2:0]        digit_q, digit_d;
    logic [31:0]       latched_q, latched_d;
    logic [4:0]        lsel_q, lsel_d;
    logic              scan_last, frame_start;

    assign scan_last   = (scan_q == SCAN_LAST);
    // The first blank cycle of digit 0 occurs both right after reset and
    // right after the 7->0 wrap. A whole frame therefore shows one coherent snapshot.
    assign frame_start = (scan_q == '0) && (digit_q == 3'd0);

    always_comb begin
        scan_d    = scan_last ? '0 : scan_q + SCAN_W'(1);
        digit_d   = scan_last ? digit_q + 3'd1 : digit_q;
        latched_d = frame_start ? value : latched_q;
        lsel_d    = frame_start ? sel_q : lsel_q;
    end

    // ---------------- registered display outputs ----------------
    logic [7:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [3:0] nibble;
    logic       lsel_is_s;

    assign nibble    = latched_q[{digit_q, 2'b00} +: 4];
    assign lsel_is_s = (lsel_q >= S_REG_LO) && (lsel_q <= S_REG_HI);

    // Count 0 of every slot blanks all anodes. This gives the previous digit's
    // segment drive a cycle to clear before the next anode turns on.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (scan_q != '0) begin
            an_d  = ~(8'd1 << digit_q);
            seg_d = hex_to_seg(nibble);
            dp_d  = !((digit_q == 3'd7) && lsel_is_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= REG_SEL_MIN;
            scan_q    <= '0;
            digit_q   <= 3'd0;
            latched_q <= 32'd0;
            lsel_q    <= REG_SEL_MIN;
            an_q      <= 8'hFF;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            sel_q     <= sel_d;
            scan_q    <= scan_d;
            digit_q   <= digit_d;
            latched_q <= latched_d;
            lsel_q    <= lsel_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign sel = sel_q;
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_reg_display_scan.sv
module tb_reg_display_scan;

    localparam int DB  = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_next, btn_prev;
    logic [31:0] value;
    logic [4:0]  sel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    reg_display_scan #(.DB_CYCLES(DB), .SCAN_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .value    (value),
        .sel      (sel),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [31:0]      value;
        logic [7:0][6:0]  segs;
    } dvec_t;

    typedef struct {
        logic       n;
        logic       p;
        int         reps;
        logic [4:0] exp_after;
    } pvec_t;

    exp_t       exp_q[$];
    logic [4:0] sel_exp_q[$];
    dvec_t      dvecs[3];
    pvec_t      pvecs[7];
    logic [4:0] sel_model;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    function automatic logic s_reg(input logic [4:0] s);
        return (s >= 5'd16) && (s <= 5'd23);
    endfunction

    function automatic logic [4:0] step(input logic [4:0] s, input logic n, input logic p);
        if (n && p) return s;
        if (n) return (s == 5'd25) ? 5'd8 : s + 5'd1;
        if (p) return (s == 5'd8) ? 5'd25 : s - 5'd1;
        return s;
    endfunction

    task automatic push_slots(input logic [7:0][6:0] segs, input logic dpon,
                              input int from, input int to);
        for (int d = from; d <= to; d++) begin
            exp_t e;
            e.an  = ~(8'd1 << d);
            e.seg = segs[d];
            e.dp  = (d == 7 && dpon) ? 1'b0 : 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Pops one expectation at the first lit cycle of each slot. It also
    // checks the lit length of every slot it saw start from a blank cycle.
    task automatic collect(input int nslots);
        int   got = 0;
        int   run = 0;
        int   guard = 0;
        logic measuring = 1'b0;
        logic prev_blank;
        prev_blank = (an == 8'hFF);
        while (got < nslots && guard < 400) begin
            @(negedge clk);
            guard++;
            if (an == 8'hFF) begin
                if (measuring) chk("slot_len", run, DIV - 1);
                measuring  = 1'b0;
                prev_blank = 1'b1;
            end else begin
                if (prev_blank) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("slot_an", an, e.an);
                    chk("slot_seg", seg, e.seg);
                    chk("slot_dp", dp, e.dp);
                    got++;
                    measuring = 1'b1;
                    run = 1;
                end else begin
                    run++;
                end
                prev_blank = 1'b0;
            end
        end
        if (got < nslots) fail_timeout("collect");
    endtask

    task automatic wait_an(input logic [7:0] target);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (an != target && guard < 200);
        if (an != target) fail_timeout("wait_an");
    endtask

    task automatic press(input logic n, input logic p);
        sel_model = step(sel_model, n, p);
        sel_exp_q.push_back(sel_model);
        @(negedge clk);
        btn_next = n;
        btn_prev = p;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (10) @(negedge clk);
        chk("press_sel", sel, sel_exp_q.pop_front());
    endtask

    initial begin
        logic [7:0][6:0] ff_segs;
        ff_segs = {8{7'h0E}};

        dvecs[0].value = 32'h76543210;
        dvecs[0].segs  = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        dvecs[1].value = 32'hFEDCBA98;
        dvecs[1].segs  = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        dvecs[2].value = 32'h1234ABCD;
        dvecs[2].segs  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};

        pvecs[0] = '{n: 1'b0, p: 1'b1, reps: 1,  exp_after: 5'd8};
        pvecs[1] = '{n: 1'b1, p: 1'b0, reps: 17, exp_after: 5'd25};
        pvecs[2] = '{n: 1'b1, p: 1'b0, reps: 1,  exp_after: 5'd8};
        pvecs[3] = '{n: 1'b0, p: 1'b1, reps: 1,  exp_after: 5'd25};
        pvecs[4] = '{n: 1'b1, p: 1'b1, reps: 1,  exp_after: 5'd25};
        pvecs[5] = '{n: 1'b1, p: 1'b0, reps: 1,  exp_after: 5'd8};
        pvecs[6] = '{n: 1'b1, p: 1'b0, reps: 8,  exp_after: 5'd16};

        // Reset state, held across several edges.
        rst_n = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        value = dvecs[0].value;
        sel_model = 5'd8;
        repeat (3) @(negedge clk);
        chk("rst_sel", sel, 5'd8);
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);

        // The first frame after release shows the value at the inputs.
        push_slots(dvecs[0].segs, s_reg(sel_model), 0, 7);
        rst_n = 1'b1;
        collect(8);

        // Bouncy press: 1,0,1, then held. The final rise lands before edge 0.
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        @(negedge clk);
        btn_next = 1'b1;
        repeat (6) @(negedge clk);
        chk("bounce_early", sel, 5'd8);
        @(negedge clk);
        chk("bounce_latency", sel, 5'd9);
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_single", sel, 5'd9);
        sel_model = 5'd9;

        // Selector wrap sequences.
        for (int i = 0; i < 7; i++) begin
            for (int r = 0; r < pvecs[i].reps; r++) press(pvecs[i].n, pvecs[i].p);
            chk("sel_group", sel, pvecs[i].exp_after);
        end

        // Scan frames with sel=16, so digit 7 carries the decimal point.
        wait_an(8'h7F);
        for (int v = 1; v < 3; v++) begin
            value = dvecs[v].value;
            push_slots(dvecs[v].segs, s_reg(sel_model), 0, 7);
            collect(8);
        end

        // Value change mid-frame while digit 3 is lit.
        wait_an(8'hF7);
        value = 32'hFFFFFFFF;
        push_slots(dvecs[2].segs, s_reg(sel_model), 4, 7);
        push_slots(ff_segs, s_reg(sel_model), 0, 7);
        collect(12);

        // Reset arrives while the debounce count is 2 and the button is still held.
        @(negedge clk);
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", sel, 5'd8);
        chk("async_rst_an", an, 8'hFF);
        @(negedge clk);
        btn_next = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_press_sel", sel, 5'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
